// File: rtl/lsu_req_arb.sv
// Order-preserving two-lane load/store request arbiter with grant lock,
// outstanding-transaction limit and fence/drain gating.
package lsu_req_arb_pkg;
    typedef struct packed {
        logic [31:0] addr;
        logic        is_store;
        logic [1:0]  size;
    } lsu_req_info_t;

    localparam lsu_req_info_t NULL_LSU_REQ_INFO = '0;
endpackage

// state    | meaning
// ARB_IDLE | no request locked
// ARB_L0   | lane0 request presented, waiting for lsif_rdy_i
// ARB_L1   | lane1 request presented, waiting for lsif_rdy_i
module lsu_req_arb
    import lsu_req_arb_pkg::*;
#(
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          flush_i,
    input  logic          fence_i,
    input  logic          l0_valid_i,
    input  lsu_req_info_t l0_req_i,
    output logic          l0_rdy_o,
    input  logic          l1_valid_i,
    input  lsu_req_info_t l1_req_i,
    output logic          l1_rdy_o,
    input  logic          lsif_rdy_i,
    output logic          us_valid_o,
    output lsu_req_info_t lsu_req_dec_o,
    input  logic          lsu_resp_i,
    output logic [2:0]    outstanding_o,
    output logic          arb_busy_o
);

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_L0   = 2'd1,
        ARB_L1   = 2'd2
    } arb_state_e;

    arb_state_e state_q, state_d;
    logic [2:0] cnt_q, cnt_d;

    logic full;
    logic gnt_en;
    logic sel_l0;
    logic sel_l1;
    logic transfer;

    assign full   = (cnt_q == 3'(MaxOutstanding));
    assign gnt_en = ~flush_i & ~full & ~(fence_i & (cnt_q != 3'd0));

    always_comb begin
        sel_l0 = 1'b0;
        sel_l1 = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                // Lane0 is older, so it always wins; lane1 waits a cycle.
                if (gnt_en && l0_valid_i) begin
                    sel_l0 = 1'b1;
                end else if (gnt_en && l1_valid_i) begin
                    sel_l1 = 1'b1;
                end
            end
            // Limits were checked at grant time; a locked request is not re-qualified.
            ARB_L0:  sel_l0 = ~flush_i;
            ARB_L1:  sel_l1 = ~flush_i;
            default: ;
        endcase
    end

    assign us_valid_o    = sel_l0 | sel_l1;
    assign lsu_req_dec_o = sel_l1 ? l1_req_i : l0_req_i;
    assign l0_rdy_o      = sel_l0 & lsif_rdy_i;
    assign l1_rdy_o      = sel_l1 & lsif_rdy_i;
    assign transfer      = us_valid_o & lsif_rdy_i;

    always_comb begin
        state_d = ARB_IDLE;
        if (sel_l0 && !lsif_rdy_i) begin
            state_d = ARB_L0;
        end else if (sel_l1 && !lsif_rdy_i) begin
            state_d = ARB_L1;
        end
    end

    // Flush never clears the count: responses for accepted requests still arrive.
    always_comb begin
        cnt_d = cnt_q;
        case ({transfer, lsu_resp_i})
            2'b10:   cnt_d = cnt_q + 3'd1;
            2'b01:   cnt_d = (cnt_q != 3'd0) ? cnt_q - 3'd1 : cnt_q;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ARB_IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign outstanding_o = cnt_q;
    assign arb_busy_o    = (state_q != ARB_IDLE) | (cnt_q != 3'd0);

endmodule

// File: tb/tb_lsu_req_arb.sv
// Directed bench for lsu_req_arb: accepted transfers are checked by a
// scoreboard monitor, counter/valid/busy behaviour by inline checks.
module tb_lsu_req_arb;
    import lsu_req_arb_pkg::*;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          flush_i, fence_i;
    logic          l0_valid_i, l1_valid_i;
    lsu_req_info_t l0_req_i, l1_req_i;
    logic          l0_rdy_o, l1_rdy_o;
    logic          lsif_rdy_i;
    logic          us_valid_o;
    lsu_req_info_t lsu_req_dec_o;
    logic          lsu_resp_i;
    logic [2:0]    outstanding_o;
    logic          arb_busy_o;

    typedef struct packed {
        logic          lane;
        lsu_req_info_t req;
    } xfer_t;

    xfer_t exp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    lsu_req_arb #(.MaxOutstanding(2)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .fence_i(fence_i),
        .l0_valid_i(l0_valid_i), .l0_req_i(l0_req_i), .l0_rdy_o(l0_rdy_o),
        .l1_valid_i(l1_valid_i), .l1_req_i(l1_req_i), .l1_rdy_o(l1_rdy_o),
        .lsif_rdy_i(lsif_rdy_i), .us_valid_o(us_valid_o), .lsu_req_dec_o(lsu_req_dec_o),
        .lsu_resp_i(lsu_resp_i), .outstanding_o(outstanding_o), .arb_busy_o(arb_busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Monitor: every accepted transfer must match the next expected one.
    always @(negedge clk_i) begin
        if (rst_ni && us_valid_o && lsif_rdy_i) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_xfer: lane %0d req %0h, none expected", l1_rdy_o, lsu_req_dec_o);
            end else begin
                xfer_t e;
                e = exp_q.pop_front();
                chk("xfer_lane", 64'({l1_rdy_o, l0_rdy_o}), e.lane ? 64'd2 : 64'd1);
                chk("xfer_req", 64'(lsu_req_dec_o), 64'(e.req));
            end
        end
    end

    function automatic lsu_req_info_t mk(input logic [31:0] a, input logic st);
        lsu_req_info_t r;
        r.addr = a;
        r.is_store = st;
        r.size = a[1:0];
        return r;
    endfunction

    // Apply one cycle of inputs at posedge+1; checks follow at posedge+4.
    task automatic drive(input logic v0, input lsu_req_info_t p0, input logic v1,
                         input lsu_req_info_t p1, input logic rdy, input logic resp,
                         input logic fence, input logic flush);
        @(posedge clk_i);
        #1;
        l0_valid_i = v0; l0_req_i = p0;
        l1_valid_i = v1; l1_req_i = p1;
        lsif_rdy_i = rdy; lsu_resp_i = resp;
        fence_i = fence; flush_i = flush;
        #3;
    endtask

    task automatic idle(input logic resp);
        drive(1'b0, NULL_LSU_REQ_INFO, 1'b0, NULL_LSU_REQ_INFO, 1'b0, resp, 1'b0, 1'b0);
    endtask

    task automatic expect_xfer(input logic lane, input lsu_req_info_t r);
        xfer_t e;
        e.lane = lane;
        e.req  = r;
        exp_q.push_back(e);
    endtask

    lsu_req_info_t pa, pb, pc, pd, pe, pf, pg, ph, pi, pj, pk, pl, pm;

    initial begin
        pa = mk(32'h1000, 1'b0); pb = mk(32'h2004, 1'b1); pc = mk(32'h3008, 1'b0);
        pd = mk(32'h400c, 1'b1); pe = mk(32'h5001, 1'b0); pf = mk(32'h6002, 1'b1);
        pg = mk(32'h7003, 1'b0); ph = mk(32'h8000, 1'b1); pi = mk(32'h9004, 1'b0);
        pj = mk(32'ha008, 1'b1); pk = mk(32'hb00c, 1'b0); pl = mk(32'hc001, 1'b1);
        pm = mk(32'hd002, 1'b0);
        rst_ni = 1'b0; flush_i = 1'b0; fence_i = 1'b0;
        l0_valid_i = 1'b0; l1_valid_i = 1'b0; l0_req_i = '0; l1_req_i = '0;
        lsif_rdy_i = 1'b0; lsu_resp_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #4;
        chk("rst_us_valid", 64'(us_valid_o), 64'd0);
        chk("rst_rdy", 64'({l1_rdy_o, l0_rdy_o}), 64'd0);
        chk("rst_cnt", 64'(outstanding_o), 64'd0);
        chk("rst_busy", 64'(arb_busy_o), 64'd0);
        chk("rst_req", 64'(lsu_req_dec_o), 64'(NULL_LSU_REQ_INFO));
        rst_ni = 1'b1;

        // Pair issued together: lane0 then lane1, then full.
        expect_xfer(1'b0, pa);
        drive(1'b1, pa, 1'b1, pb, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("pair_c0_rdy", 64'({l1_rdy_o, l0_rdy_o}), 64'd1);
        expect_xfer(1'b1, pb);
        drive(1'b0, pc, 1'b1, pb, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("pair_c1_cnt", 64'(outstanding_o), 64'd1);
        chk("pair_c1_rdy", 64'({l1_rdy_o, l0_rdy_o}), 64'd2);
        drive(1'b1, pc, 1'b0, pc, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("pair_c2_cnt", 64'(outstanding_o), 64'd2);
        chk("pair_c2_full_valid", 64'(us_valid_o), 64'd0);
        chk("pair_c2_busy", 64'(arb_busy_o), 64'd1);
        idle(1'b1);
        idle(1'b1);
        idle(1'b0);
        chk("drain_cnt", 64'(outstanding_o), 64'd0);

        // Lane0 stalled for three cycles, accepted on the fourth.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, pd, 1'b0, pa, 1'b0, 1'b0, 1'b0, 1'b0);
            chk("stall_valid", 64'(us_valid_o), 64'd1);
            chk("stall_rdy", 64'(l0_rdy_o), 64'd0);
            chk("stall_req", 64'(lsu_req_dec_o), 64'(pd));
            if (i > 0) chk("stall_locked_busy", 64'(arb_busy_o), 64'd1);
        end
        expect_xfer(1'b0, pd);
        drive(1'b1, pd, 1'b0, pa, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("stall_accept_rdy", 64'(l0_rdy_o), 64'd1);
        idle(1'b0);
        chk("stall_cnt", 64'(outstanding_o), 64'd1);
        idle(1'b1);
        idle(1'b0);

        // Full, lane1 waits for a response, then is granted.
        expect_xfer(1'b0, pe);
        drive(1'b1, pe, 1'b0, pa, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_xfer(1'b0, pf);
        drive(1'b1, pf, 1'b0, pa, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, pa, 1'b1, pg, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("full_cnt", 64'(outstanding_o), 64'd2);
        chk("full_no_valid", 64'(us_valid_o), 64'd0);
        drive(1'b0, pa, 1'b1, pg, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("full_resp_no_valid", 64'(us_valid_o), 64'd0);
        expect_xfer(1'b1, pg);
        drive(1'b0, pa, 1'b1, pg, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("full_after_resp_cnt", 64'(outstanding_o), 64'd1);
        chk("full_after_resp_l1_rdy", 64'(l1_rdy_o), 64'd1);
        idle(1'b1);
        chk("full_refill_cnt", 64'(outstanding_o), 64'd2);
        idle(1'b1);
        idle(1'b0);

        // Fence holds lane0 until the count drains to zero.
        expect_xfer(1'b0, ph);
        drive(1'b1, ph, 1'b0, pa, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, pi, 1'b0, pa, 1'b1, 1'b0, 1'b1, 1'b0);
            chk("fence_block", 64'(us_valid_o), 64'd0);
        end
        drive(1'b1, pi, 1'b0, pa, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("fence_resp_block", 64'(us_valid_o), 64'd0);
        expect_xfer(1'b0, pi);
        drive(1'b1, pi, 1'b0, pa, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("fence_drained_cnt", 64'(outstanding_o), 64'd0);
        chk("fence_grant", 64'(l0_rdy_o), 64'd1);
        idle(1'b1);
        idle(1'b0);

        // Lock lane1, flush drops it without counting.
        drive(1'b0, pa, 1'b1, pj, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("l1_lock_valid", 64'(us_valid_o), 64'd1);
        chk("l1_lock_req", 64'(lsu_req_dec_o), 64'(pj));
        drive(1'b0, pa, 1'b1, pj, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("l1_locked_busy", 64'(arb_busy_o), 64'd1);
        drive(1'b0, pa, 1'b1, pj, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("flush_valid", 64'(us_valid_o), 64'd0);
        chk("flush_l1_rdy", 64'(l1_rdy_o), 64'd0);
        expect_xfer(1'b0, pk);
        drive(1'b1, pk, 1'b1, pj, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("post_flush_cnt", 64'(outstanding_o), 64'd0);
        chk("post_flush_l0_first", 64'({l1_rdy_o, l0_rdy_o}), 64'd1);
        idle(1'b1);
        idle(1'b0);

        // Simultaneous transfer and response; response at zero is ignored.
        expect_xfer(1'b0, pl);
        drive(1'b1, pl, 1'b0, pa, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_xfer(1'b0, pm);
        drive(1'b1, pm, 1'b0, pa, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(1'b0);
        chk("xfer_resp_cnt", 64'(outstanding_o), 64'd1);
        idle(1'b1);
        idle(1'b1);
        idle(1'b0);
        chk("resp_at_zero_cnt", 64'(outstanding_o), 64'd0);

        // Asynchronous reset while locked with a nonzero count.
        expect_xfer(1'b0, pa);
        drive(1'b1, pa, 1'b0, pb, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, pc, 1'b0, pb, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, pc, 1'b0, pb, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("pre_reset_busy", 64'(arb_busy_o), 64'd1);
        l0_valid_i = 1'b0;
        rst_ni = 1'b0;
        #1;
        chk("async_rst_busy", 64'(arb_busy_o), 64'd0);
        chk("async_rst_cnt", 64'(outstanding_o), 64'd0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        idle(1'b0);

        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d transfers pending, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
